// File: rtl/irig_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module   : irig_symbol_decoder
// Purpose  : IRIG pulse-width symbol decoder with double-marker frame
//            alignment and carrier-loss detection. Sits between the raw IRIG
//            input pin and the time-code deserialiser.
// Ports    : clk, rst          - system clock, synchronous active-high reset
//            irig_in           - raw asynchronous IRIG DC-level input
//            sym_valid         - one-cycle pulse when a symbol is classified
//            sym               - 00 ZERO, 01 ONE, 10 MARK, 11 ERROR (held)
//            pulse_width       - measured high width in clk cycles (held)
//            bit_idx           - frame index of last symbol, valid while locked
//            frame_start       - one-cycle pulse for the index-0 marker
//            locked            - frame alignment held
//            frame_err         - one-cycle pulse when alignment is lost
//            carrier_lost      - no filtered rising edge for 2 bit periods
// Revision : 1.0 - initial release
// ============================================================================
module irig_symbol_decoder #(
    parameter int CLK_HZ     = 10000000,
    parameter int BIT_HZ     = 100,
    parameter int FILT_LEN   = 4,
    parameter int FRAME_BITS = 100,
    parameter int CNT_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             irig_in,
    output logic             sym_valid,
    output logic [1:0]       sym,
    output logic [CNT_W-1:0] pulse_width,
    output logic [6:0]       bit_idx,
    output logic             frame_start,
    output logic             locked,
    output logic             frame_err,
    output logic             carrier_lost
);

    // Cycles per bit and classification thresholds (integer division).
    localparam int               c_P        = CLK_HZ / BIT_HZ;
    localparam logic [CNT_W-1:0] c_T_ZERO   = CNT_W'(c_P / 10);
    localparam logic [CNT_W-1:0] c_T_ONE    = CNT_W'((35 * c_P) / 100);
    localparam logic [CNT_W-1:0] c_T_MARK   = CNT_W'((65 * c_P) / 100);
    localparam logic [CNT_W-1:0] c_T_ERR    = CNT_W'((95 * c_P) / 100);
    localparam logic [CNT_W-1:0] c_TWO_P_M1 = CNT_W'(2 * c_P - 1);

    localparam logic [1:0] c_SYM_ZERO = 2'b00;
    localparam logic [1:0] c_SYM_ONE  = 2'b01;
    localparam logic [1:0] c_SYM_MARK = 2'b10;
    localparam logic [1:0] c_SYM_ERR  = 2'b11;

    localparam int             c_FC_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [c_FC_W-1:0] c_FC_MAX = c_FC_W'(FILT_LEN - 1);
    localparam logic [6:0]     c_LAST_IDX = 7'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_HUNT     = 2'd0,
        S_GOT_MARK = 2'd1,
        S_LOCKED   = 2'd2
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_filt;
    logic              r_filt_d;
    logic [c_FC_W-1:0] r_fcnt;
    logic [CNT_W-1:0]  r_wcnt;
    logic [CNT_W-1:0]  r_ptmr;
    state_t            r_state;

    logic       w_rise;
    logic       w_fall;
    logic       w_cl_set;
    logic [1:0] w_class;
    logic [6:0] w_next_idx;
    logic       w_is_marker;
    logic       w_sym_ok;

    // ------------------------------------------------------------------------
    // Synchroniser and glitch filter. The filtered level only follows the
    // synchronised input after FILT_LEN consecutive differing cycles, so both
    // edges see the same latency and measured widths are preserved.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
            r_fcnt   <= '0;
        end else begin
            r_sync1  <= irig_in;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            if (r_sync2 != r_filt) begin
                if (r_fcnt == c_FC_MAX) begin
                    r_filt <= r_sync2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + c_FC_W'(1);
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // First filtered-high cycle / first filtered-low cycle after a pulse.
    assign w_rise = r_filt & ~r_filt_d;
    assign w_fall = ~r_filt & r_filt_d;

    // Timer reaches 2P on this edge with no rising edge to restart it.
    assign w_cl_set = ~w_rise & (r_ptmr == c_TWO_P_M1);

    // ------------------------------------------------------------------------
    // Width counter, period timer and carrier-loss flag.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt       <= '0;
            r_ptmr       <= '0;
            carrier_lost <= 1'b0;
        end else begin
            if (w_rise) begin
                r_wcnt <= CNT_W'(1);
            end else if (r_filt && (r_wcnt != '1)) begin
                r_wcnt <= r_wcnt + CNT_W'(1);
            end

            if (w_rise) begin
                r_ptmr       <= '0;
                carrier_lost <= 1'b0;
            end else begin
                if (r_ptmr != '1) begin
                    r_ptmr <= r_ptmr + CNT_W'(1);
                end
                if (w_cl_set) begin
                    carrier_lost <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pulse classification against the tolerance windows.
    // ------------------------------------------------------------------------
    always_comb begin
        w_class = c_SYM_ERR;
        if (r_wcnt < c_T_ZERO) begin
            w_class = c_SYM_ERR;
        end else if (r_wcnt < c_T_ONE) begin
            w_class = c_SYM_ZERO;
        end else if (r_wcnt < c_T_MARK) begin
            w_class = c_SYM_ONE;
        end else if (r_wcnt < c_T_ERR) begin
            w_class = c_SYM_MARK;
        end else begin
            w_class = c_SYM_ERR;
        end
    end

    // Index the incoming symbol will occupy, and whether it must be a marker.
    assign w_next_idx  = (bit_idx == c_LAST_IDX) ? 7'd0 : bit_idx + 7'd1;
    assign w_is_marker = (w_next_idx == 7'd0) || ((w_next_idx % 7'd10) == 7'd9);
    assign w_sym_ok    = w_is_marker ? (w_class == c_SYM_MARK)
                                     : ((w_class == c_SYM_ZERO) || (w_class == c_SYM_ONE));

    // ------------------------------------------------------------------------
    // Symbol outputs and frame alignment state machine.
    // A carrier-loss assertion takes priority over any symbol-driven move.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_HUNT;
            sym_valid   <= 1'b0;
            sym         <= 2'b00;
            pulse_width <= '0;
            bit_idx     <= 7'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sym_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_err   <= 1'b0;

            if (w_fall) begin
                sym_valid   <= 1'b1;
                sym         <= w_class;
                pulse_width <= r_wcnt;
            end

            if (w_cl_set) begin
                r_state <= S_HUNT;
                locked  <= 1'b0;
            end else if (w_fall) begin
                case (r_state)
                    S_HUNT: begin
                        if (w_class == c_SYM_MARK) begin
                            r_state <= S_GOT_MARK;
                        end
                    end
                    S_GOT_MARK: begin
                        if (w_class == c_SYM_MARK) begin
                            r_state     <= S_LOCKED;
                            locked      <= 1'b1;
                            bit_idx     <= 7'd0;
                            frame_start <= 1'b1;
                        end else begin
                            r_state <= S_HUNT;
                        end
                    end
                    S_LOCKED: begin
                        if (w_sym_ok) begin
                            bit_idx     <= w_next_idx;
                            frame_start <= (w_next_idx == 7'd0);
                        end else begin
                            frame_err <= 1'b1;
                            locked    <= 1'b0;
                            // A misplaced MARK may be the first of a new pair.
                            r_state   <= (w_class == c_SYM_MARK) ? S_GOT_MARK : S_HUNT;
                        end
                    end
                    default: begin
                        r_state <= S_HUNT;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irig_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_irig_symbol_decoder
// Purpose  : Self-checking bench for irig_symbol_decoder. Raw pulses are
//            generated as (high, low) segments; expected symbol events and
//            filtered rising edges are scheduled from the raw edge times, and
//            a per-cycle compare process checks every output against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irig_symbol_decoder;

    localparam int CLK_HZ     = 10000;
    localparam int BIT_HZ     = 100;
    localparam int FILT_LEN   = 4;
    localparam int FRAME_BITS = 100;
    localparam int CNT_W      = 12;
    localparam int P          = CLK_HZ / BIT_HZ;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             irig_in = 1'b0;
    logic             sym_valid;
    logic [1:0]       sym;
    logic [CNT_W-1:0] pulse_width;
    logic [6:0]       bit_idx;
    logic             frame_start;
    logic             locked;
    logic             frame_err;
    logic             carrier_lost;

    irig_symbol_decoder #(
        .CLK_HZ    (CLK_HZ),
        .BIT_HZ    (BIT_HZ),
        .FILT_LEN  (FILT_LEN),
        .FRAME_BITS(FRAME_BITS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irig_in     (irig_in),
        .sym_valid   (sym_valid),
        .sym         (sym),
        .pulse_width (pulse_width),
        .bit_idx     (bit_idx),
        .frame_start (frame_start),
        .locked      (locked),
        .frame_err   (frame_err),
        .carrier_lost(carrier_lost)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic rst_q    = 1'b1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    typedef struct {
        int due;
        int w;
    } sym_ev_t;

    sym_ev_t sym_q[$];
    int      rise_q[$];

    // Behavioural model state
    int m_mode;      // 0 hunting, 1 one mark seen, 2 aligned
    int m_idx;
    bit m_locked;
    bit m_cl;
    int last_rise;
    int m_sym;
    int m_pw;
    bit e_sv, e_fs, e_fe, e_cl;

    // Observed DUT symbol log for literal expectations
    int log_sym[$];
    int log_pw[$];
    int log_cyc[$];
    int dut_fs_cnt = 0;
    int dut_fe_cnt = 0;
    int last_ef    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int classify(input int w);
        if (w < P / 10)         return 3;
        if (w < (35 * P) / 100) return 0;
        if (w < (65 * P) / 100) return 1;
        if (w < (95 * P) / 100) return 2;
        return 3;
    endfunction

    function automatic bit is_marker(input int i);
        return (i == 0) || ((i % 10) == 9);
    endfunction

    task automatic frame_step(input int s);
        int ni;
        case (m_mode)
            0: if (s == 2) m_mode = 1;
            1: begin
                if (s == 2) begin
                    m_mode = 2; m_locked = 1; m_idx = 0; e_fs = 1;
                end else begin
                    m_mode = 0;
                end
            end
            default: begin
                ni = (m_idx + 1) % FRAME_BITS;
                if (is_marker(ni) ? (s == 2) : (s < 2)) begin
                    m_idx = ni;
                    e_fs  = (ni == 0);
                end else begin
                    e_fe     = 1;
                    m_locked = 0;
                    m_mode   = (s == 2) ? 1 : 0;
                end
            end
        endcase
    endtask

    // ------------------------------------------------------------------------
    // Per-cycle compare against the model (sampled on the falling edge).
    // ------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_q) begin
                chk("rst_sym_valid", sym_valid, 0);
                chk("rst_sym", sym, 0);
                chk("rst_pulse_width", pulse_width, 0);
                chk("rst_bit_idx", bit_idx, 0);
                chk("rst_frame_start", frame_start, 0);
                chk("rst_locked", locked, 0);
                chk("rst_frame_err", frame_err, 0);
                chk("rst_carrier_lost", carrier_lost, 0);
                sym_q.delete();
                rise_q.delete();
                m_mode = 0; m_idx = 0; m_locked = 0; m_cl = 0;
                m_sym = 0; m_pw = 0;
                last_rise = cyc - 1;
            end else begin
                e_sv = 0; e_fs = 0; e_fe = 0;
                e_cl = ((cyc - last_rise) >= 2 * P + 1);
                if (e_cl && !m_cl) begin
                    m_mode   = 0;
                    m_locked = 0;
                end
                m_cl = e_cl;
                if (rise_q.size() > 0 && rise_q[0] == cyc) begin
                    last_rise = cyc;
                    void'(rise_q.pop_front());
                end
                if (sym_q.size() > 0 && sym_q[0].due == cyc) begin
                    sym_ev_t ev;
                    ev    = sym_q.pop_front();
                    e_sv  = 1;
                    m_sym = classify(ev.w);
                    m_pw  = ev.w;
                    frame_step(m_sym);
                end
                chk("sym_valid", sym_valid, e_sv);
                chk("sym", sym, m_sym);
                chk("pulse_width", pulse_width, m_pw);
                chk("locked", locked, m_locked);
                chk("frame_start", frame_start, e_fs);
                chk("frame_err", frame_err, e_fe);
                chk("carrier_lost", carrier_lost, e_cl);
                if (m_locked) chk("bit_idx", bit_idx, m_idx);
                if (sym_valid === 1'b1) begin
                    log_sym.push_back(int'(sym));
                    log_pw.push_back(int'(pulse_width));
                    log_cyc.push_back(cyc);
                end
                if (frame_start === 1'b1) dut_fs_cnt++;
                if (frame_err === 1'b1)   dut_fe_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers. All driving happens 1 time unit after a rising edge.
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hw, input int lw);
        int er;
        irig_in = 1'b1;
        er = cyc;
        rise_q.push_back(er + 2 + FILT_LEN);
        tick(hw);
        irig_in = 1'b0;
        last_ef = cyc;
        sym_q.push_back('{due: cyc + 3 + FILT_LEN, w: cyc - er});
        tick(lw);
    endtask

    task automatic send_sym(input int kind);
        int w;
        case (kind)
            0:       w = $urandom_range(10, 34);
            1:       w = $urandom_range(35, 64);
            default: w = $urandom_range(65, 94);
        endcase
        pulse(w, P - w);
    endtask

    task automatic send_frame_idx(input int i);
        if (is_marker(i)) send_sym(2);
        else              send_sym(int'($urandom_range(0, 1)));
    endtask

    function automatic int lsym(input int i);
        return (i < log_sym.size()) ? log_sym[i] : -1;
    endfunction

    function automatic int lpw(input int i);
        return (i < log_pw.size()) ? log_pw[i] : -1;
    endfunction

    function automatic int lcyc(input int i);
        return (i < log_cyc.size()) ? log_cyc[i] : -1;
    endfunction

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    int bw[8]   = '{9, 10, 34, 35, 64, 65, 94, 95};
    int bsym[8] = '{3, 0, 0, 1, 1, 2, 2, 3};

    initial begin
        int base, ef0, fs0, fe0;
        rst = 1'b1;
        irig_in = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(10);

        // Clean ZERO / ONE / MARK pulses and classification latency
        base = log_sym.size();
        pulse(20, 80);
        ef0 = last_ef;
        pulse(50, 50);
        pulse(80, 20);
        tick(10);
        chk("lit_zero_sym", lsym(base), 0);
        chk("lit_zero_pw", lpw(base), 20);
        chk("lit_one_sym", lsym(base + 1), 1);
        chk("lit_one_pw", lpw(base + 1), 50);
        chk("lit_mark_sym", lsym(base + 2), 2);
        chk("lit_mark_pw", lpw(base + 2), 80);
        chk("lit_latency", lcyc(base) - ef0, FILT_LEN + 3);

        // Threshold boundaries
        base = log_sym.size();
        for (int k = 0; k < 8; k++) pulse(bw[k], (bw[k] >= 90) ? 20 : P - bw[k]);
        tick(10);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("lit_bound_%0d_sym", bw[k]), lsym(base + k), bsym[k]);
            chk($sformatf("lit_bound_%0d_pw", bw[k]), lpw(base + k), bw[k]);
        end

        // Low glitch inside a ONE pulse, then high spike in the low time
        base = log_sym.size();
        irig_in = 1'b1;
        rise_q.push_back(cyc + 2 + FILT_LEN);
        tick(20); irig_in = 1'b0;
        tick(3);  irig_in = 1'b1;
        tick(27); irig_in = 1'b0;
        sym_q.push_back('{due: cyc + 3 + FILT_LEN, w: 50});
        tick(20); irig_in = 1'b1;
        tick(3);  irig_in = 1'b0;
        tick(27);
        tick(10);
        chk("lit_glitch_count", log_sym.size() - base, 1);
        chk("lit_glitch_sym", lsym(base), 1);
        chk("lit_glitch_pw", lpw(base), 50);

        // Hunt noise, double marker, one full frame plus wrap, error at 19
        send_sym(0);
        send_sym(1);
        fs0 = dut_fs_cnt;
        fe0 = dut_fe_cnt;
        send_sym(2);
        send_sym(2);
        for (int k = 1; k <= 118; k++) send_frame_idx(k % FRAME_BITS);
        tick(10);
        chk("lit_frame_locked", locked, 1);
        chk("lit_frame_idx", bit_idx, 18);
        chk("lit_frame_starts", dut_fs_cnt - fs0, 2);
        send_sym(0);
        tick(10);
        chk("lit_err_locked", locked, 0);
        chk("lit_err_pulses", dut_fe_cnt - fe0, 1);

        // Realignment
        send_sym(2);
        send_sym(2);
        tick(10);
        chk("lit_relock", locked, 1);
        chk("lit_relock_idx", bit_idx, 0);
        for (int k = 1; k <= 30; k++) send_frame_idx(k);

        // Carrier loss and recovery
        tick(500);
        chk("lit_cl_set", carrier_lost, 1);
        chk("lit_cl_unlocked", locked, 0);
        send_sym(2);
        chk("lit_cl_cleared", carrier_lost, 0);

        // Stuck-high pulse: carrier lost during it, ERROR when it falls
        base = log_sym.size();
        pulse(300, 50);
        chk("lit_stuck_sym", lsym(base), 3);
        chk("lit_stuck_pw", lpw(base), 300);

        // Lock again then reset mid-frame
        send_sym(2);
        send_sym(2);
        for (int k = 1; k <= 12; k++) send_frame_idx(k);
        tick(20);
        chk("lit_pre_rst_locked", locked, 1);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("lit_post_rst_locked", locked, 0);
        chk("lit_post_rst_idx", bit_idx, 0);
        send_sym(2);
        send_sym(2);
        send_sym(1);
        tick(20);

        chk("pending_events", sym_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/irig_symbol_decoder.md
Name: irig_symbol_decoder

Overview:
Parametrised IRIG pulse-width symbol decoder with frame alignment. It sits between the raw IRIG input pin and the time-code deserialiser. The block:
- synchronises and glitch-filters the input
- classifies each high pulse against clock-derived tolerance windows into ZERO/ONE/MARK/ERROR
- locks onto the double-marker frame reference and reports the bit index and frame start
- detects loss of carrier

Parameters:
CLK_HZ, 10000000, system clock frequency in Hz
BIT_HZ, 100, IRIG bit rate (100 = IRIG-B); P = CLK_HZ/BIT_HZ cycles per bit
FILT_LEN, 4, cycles the synchronised input must be stable before the filtered level changes (>=1)
FRAME_BITS, 100, symbols per frame; markers at every index i where (i mod 10)==9, plus index 0
CNT_W, 24, width of internal counters; must satisfy 2^CNT_W > 2*P

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
irig_in  in  1  raw asynchronous IRIG DC-level input
sym_valid  out  1  one-cycle pulse: new symbol classified
sym  out  2  00 ZERO, 01 ONE, 10 MARK, 11 ERROR; held until next sym_valid
pulse_width  out  CNT_W  measured high width in cycles; updates with sym_valid
bit_idx  out  7  index of last symbol in frame, 0..FRAME_BITS-1; valid while locked
frame_start  out  1  one-cycle pulse, coincident with sym_valid, for the index-0 marker
locked  out  1  frame alignment held
frame_err  out  1  one-cycle pulse: alignment lost on a symbol violation
carrier_lost  out  1  level: no filtered rising edge for 2*P cycles

Behaviour:
- Reset (rst=1 at clk edge): every output is 0. Synchroniser, filter level and counters clear. Filtered level = 0.
- Input path:
  - 2-flop synchroniser feeds the filter.
  - The filter changes its level only after the synchronised input differs from it for FILT_LEN consecutive cycles.
  - Shorter glitches are discarded.
  - Total delay is FILT_LEN+2 cycles, identical on both edges, so measured widths are unaffected.
- Width counter:
  - Set to 1 on the first filtered-high cycle.
  - Increments each high cycle and saturates at all-ones.
  - Width = number of filtered-high cycles.
- Classification: on the cycle after a filtered falling edge, assert sym_valid for exactly 1 cycle and latch pulse_width. Let W = width:
  - W < P/10 -> ERROR
  - P/10 <= W < 35P/100 -> ZERO
  - 35P/100 <= W < 65P/100 -> ONE
  - 65P/100 <= W < 95P/100 -> MARK
  - W >= 95P/100 -> ERROR
  - All thresholds use integer division, computed as constants.
- Period/carrier timer:
  - Clears on each filtered rising edge and saturates.
  - carrier_lost=1 once the timer reaches 2P.
  - carrier_lost=0 on the next filtered rising edge.
  - carrier_lost forces locked=0. It does not pulse frame_err.
  - A stuck-high input reaching 2P produces no sym_valid until it falls; that pulse is then classified ERROR.
- Frame state machine, states HUNT, GOT_MARK, LOCKED:
  - HUNT: MARK -> GOT_MARK. Any other symbol stays in HUNT.
  - GOT_MARK: MARK -> LOCKED, bit_idx=0, frame_start=1 with that sym_valid. ZERO/ONE -> HUNT. ERROR -> HUNT.
  - LOCKED: each symbol sets bit_idx = (bit_idx+1) mod FRAME_BITS.
    - The symbol must be MARK at marker indices and ZERO/ONE elsewhere.
    - A MARK at new index 0 pulses frame_start.
    - A violation or ERROR pulses frame_err, sets locked=0 and goes to HUNT. A violating MARK moves to GOT_MARK instead, allowing realignment on the next MARK.
  - locked=1 exactly in LOCKED. bit_idx and frame_start update in the same cycle as sym_valid.
- Simultaneous events: the carrier_lost assertion cycle overrides any state transition -> HUNT.
- rst mid-pulse: the pulse is discarded. A pulse already high when rst deasserts is not counted until the next filtered rising edge.

Test Plan:
1. Defaults. Clean pulses 2 ms, 5 ms, 8 ms (20000/50000/80000 cycles) at 10 ms period -> sym=00/01/10, pulse_width=20000/50000/80000. sym_valid rises 1 cycle after the filtered fall, i.e. FILT_LEN+3 cycles after the raw fall.
2. Boundary widths 9999/10000, 34999/35000, 64999/65000, 94999/95000 cycles -> ERROR/ZERO, ZERO/ONE, ONE/MARK, MARK/ERROR.
3. 3-cycle low glitch inside a 50000-cycle pulse, and 3-cycle high spike in low time -> single ONE, no extra sym_valid.
4. Full frame: MARK, MARK, then valid IRIG-B pattern -> locked=1 and frame_start on the 2nd MARK. bit_idx counts 0..99 and wraps. frame_start recurs every 100 symbols.
5. While locked, ZERO at index 19 -> frame_err pulse, locked=0. Two MARKs -> relock with bit_idx=0.
6. Input held low 2,000,000 cycles -> carrier_lost=1, locked=0. Resuming pulses -> carrier_lost=0 on the first rising edge. rst asserted mid-frame -> all outputs 0 the next cycle.
